// File: rtl/pipe_hazard_sb.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_sb
// Purpose  : ID-stage hazard / forwarding unit for a 5-stage pipeline with a
//            scoreboard for a fixed-latency multiply/divide unit (MDU) that
//            owns a private regfile write port.
// Ports    : clock, reset           - rising-edge clock, sync active-high reset
//            id_*                   - pre-decoded ID instruction info
//            ern/ewreg/em2reg       - EX-stage destination, write, load flag
//            mrn/mwreg/mm2reg       - MEM-stage destination, write, load flag
//            fwda/fwdb              - 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load
//            nostall, issue         - pipeline advance / instruction accepted
//            mdu_busy, mdu_wb, mdu_wn - MDU occupancy and writeback port
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_sb #(
  parameter int AW       = 5,
  parameter int MDU_LAT  = 4,
  parameter int MDU_PIPE = 0,
  parameter int FWD_EN   = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic          id_use_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rt,
  input  logic [AW-1:0] id_rd,
  input  logic          id_wreg,
  input  logic          id_mdu,
  input  logic [AW-1:0] ern,
  input  logic          ewreg,
  input  logic          em2reg,
  input  logic [AW-1:0] mrn,
  input  logic          mwreg,
  input  logic          mm2reg,
  output logic [1:0]    fwda,
  output logic [1:0]    fwdb,
  output logic          nostall,
  output logic          issue,
  output logic          mdu_busy,
  output logic          mdu_wb,
  output logic [AW-1:0] mdu_wn
);

  localparam int NREG   = 1 << AW;
  localparam bit NO_FWD = (FWD_EN == 0);
  localparam bit SERIAL = (MDU_PIPE == 0);

  // Shift chain: an op enters at the top slot and reaches slot 0 in the
  // cycle its result is written to the regfile.
  logic [MDU_LAT-1:0] slot_valid;
  logic [AW-1:0]      slot_tag [MDU_LAT];
  logic [NREG-1:0]    pend;

  logic rs_live, rt_live;
  logic rs_haz, rt_haz, waw_haz, struct_haz;
  logic mdu_load;

  // Per-source stall: load-use, pending MDU result, or (without forwarding)
  // any in-flight producer in EX or MEM.
  function automatic logic src_hazard(
    input logic            live,
    input logic [AW-1:0]   src,
    input logic [NREG-1:0] pnd,
    input logic [AW-1:0]   e_rn,
    input logic            e_w,
    input logic            e_ld,
    input logic [AW-1:0]   m_rn,
    input logic            m_w
  );
    logic hit_e, hit_m;
    hit_e = e_w && (e_rn == src);
    hit_m = m_w && (m_rn == src);
    return live && ((hit_e && e_ld) || pnd[src] || (NO_FWD && (hit_e || hit_m)));
  endfunction

  // Forwarding select: the youngest producer (EX) wins; an EX load cannot
  // forward and falls through to MEM, but that case is stalled anyway.
  function automatic logic [1:0] fwd_sel(
    input logic          live,
    input logic [AW-1:0] src,
    input logic [AW-1:0] e_rn,
    input logic          e_w,
    input logic          e_ld,
    input logic [AW-1:0] m_rn,
    input logic          m_w,
    input logic          m_ld
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (live && !NO_FWD) begin
      if (e_w && !e_ld && (e_rn == src)) begin
        sel = 2'b01;
      end else if (m_w && (m_rn == src)) begin
        sel = m_ld ? 2'b11 : 2'b10;
      end
    end
    return sel;
  endfunction

  always_comb begin
    rs_live    = id_use_rs && (id_rs != '0);
    rt_live    = id_use_rt && (id_rt != '0);
    rs_haz     = src_hazard(rs_live, id_rs, pend, ern, ewreg, em2reg, mrn, mwreg);
    rt_haz     = src_hazard(rt_live, id_rt, pend, ern, ewreg, em2reg, mrn, mwreg);
    waw_haz    = (id_wreg || id_mdu) && (id_rd != '0) && pend[id_rd];
    struct_haz = SERIAL && id_mdu && mdu_busy;
    nostall    = !id_valid || !(rs_haz || rt_haz || waw_haz || struct_haz);
    issue      = id_valid && nostall;
    mdu_load   = issue && id_mdu;
    fwda       = fwd_sel(rs_live, id_rs, ern, ewreg, em2reg, mrn, mwreg, mm2reg);
    fwdb       = fwd_sel(rt_live, id_rt, ern, ewreg, em2reg, mrn, mwreg, mm2reg);
  end

  always_comb begin
    mdu_busy = |slot_valid;
    mdu_wb   = slot_valid[0] && (slot_tag[0] != '0);
    mdu_wn   = slot_valid[0] ? slot_tag[0] : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_valid <= '0;
      pend       <= '0;
      for (int i = 0; i < MDU_LAT; i++) begin
        slot_tag[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MDU_LAT - 1; i++) begin
        slot_valid[i] <= slot_valid[i+1];
        slot_tag[i]   <= slot_tag[i+1];
      end
      slot_valid[MDU_LAT-1] <= mdu_load;
      slot_tag[MDU_LAT-1]   <= mdu_load ? id_rd : '0;
      // Clear before set: a WAW stall keeps a new op from targeting the
      // register being retired, so the two never collide in practice.
      if (mdu_wb) begin
        pend[slot_tag[0]] <= 1'b0;
      end
      if (mdu_load && (id_rd != '0)) begin
        pend[id_rd] <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_sb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pipe_hazard_sb
// Purpose  : Self-checking bench for pipe_hazard_sb. Three instances share
//            one stimulus: u0 (LAT 4, serial, fwd), u1 (LAT 3, pipelined,
//            fwd), u2 (LAT 4, serial, no forwarding).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_sb;

  localparam int AW = 5;
  localparam int NI = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          id_valid, id_use_rs, id_use_rt, id_wreg, id_mdu;
  logic [AW-1:0] id_rs, id_rt, id_rd, ern, mrn;
  logic          ewreg, em2reg, mwreg, mm2reg;

  logic [1:0]    fwda     [NI];
  logic [1:0]    fwdb     [NI];
  logic          nostall  [NI];
  logic          issue    [NI];
  logic          mdu_busy [NI];
  logic          mdu_wb   [NI];
  logic [AW-1:0] mdu_wn   [NI];

  always #5 clock = ~clock;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pipe_hazard_sb #(
      .AW(AW), .MDU_LAT(g == 1 ? 3 : 4), .MDU_PIPE(g == 1 ? 1 : 0), .FWD_EN(g == 2 ? 0 : 1)
    ) u_dut (
      .clock(clock), .reset(reset), .id_valid(id_valid),
      .id_rs(id_rs), .id_use_rs(id_use_rs), .id_rt(id_rt), .id_use_rt(id_use_rt),
      .id_rd(id_rd), .id_wreg(id_wreg), .id_mdu(id_mdu),
      .ern(ern), .ewreg(ewreg), .em2reg(em2reg),
      .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg),
      .fwda(fwda[g]), .fwdb(fwdb[g]), .nostall(nostall[g]), .issue(issue[g]),
      .mdu_busy(mdu_busy[g]), .mdu_wb(mdu_wb[g]), .mdu_wn(mdu_wn[g])
    );
  end

  // ---------------- reference model: list of in-flight MDU ops ----------------
  typedef struct {
    int inst;
    int tag;
    int wbc;   // cycle in which the result is written back
  } op_t;

  op_t q[$];
  int  cyc;
  int  n_tests;
  int  n_fail;

  function automatic int lat(int k);
    return (k == 1) ? 3 : 4;
  endfunction

  function automatic bit m_pend(int k, int r);
    if (r == 0) return 1'b0;
    foreach (q[i]) if (q[i].inst == k && q[i].tag == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_busy(int k);
    foreach (q[i]) if (q[i].inst == k) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_wn(int k);
    foreach (q[i]) if (q[i].inst == k && q[i].wbc == cyc) return q[i].tag;
    return 0;
  endfunction

  function automatic bit m_src_stall(int k, bit used, int src);
    bit e_hit, m_hit;
    if (!used || src == 0) return 1'b0;
    e_hit = ewreg && (int'(ern) == src);
    m_hit = mwreg && (int'(mrn) == src);
    if (e_hit && em2reg) return 1'b1;
    if (m_pend(k, src)) return 1'b1;
    if (k == 2 && (e_hit || m_hit)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_nostall(int k);
    bit st;
    if (!id_valid) return 1'b1;
    st = m_src_stall(k, id_use_rs, int'(id_rs)) || m_src_stall(k, id_use_rt, int'(id_rt));
    if ((id_wreg || id_mdu) && id_rd != '0 && m_pend(k, int'(id_rd))) st = 1'b1;
    if (id_mdu && m_busy(k) && k != 1) st = 1'b1;
    return !st;
  endfunction

  function automatic int m_fwd(int k, bit used, int src);
    if (!used || src == 0 || k == 2) return 0;
    if (ewreg && !em2reg && int'(ern) == src) return 1;
    if (mwreg && int'(mrn) == src) return mm2reg ? 3 : 2;
    return 0;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Advance one clock, updating the model with what the edge commits.
  task automatic tick();
    op_t nq[$];
    bit  iss [NI];
    for (int k = 0; k < NI; k++) iss[k] = id_valid && m_nostall(k);
    foreach (q[i]) if (q[i].wbc != cyc) nq.push_back(q[i]);
    if (reset) begin
      nq.delete();
    end else begin
      for (int k = 0; k < NI; k++)
        if (iss[k] && id_mdu) nq.push_back('{k, int'(id_rd), cyc + lat(k)});
    end
    q = nq;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle();
    id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_wreg = 0; id_mdu = 0;
    id_rs = '0; id_rt = '0; id_rd = '0; ern = '0; mrn = '0;
    ewreg = 0; em2reg = 0; mwreg = 0; mm2reg = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic present(input int rs, input bit urs, input int rd, input bit wreg, input bit mdu);
    idle();
    id_valid = 1; id_rs = AW'(rs); id_use_rs = urs; id_rd = AW'(rd); id_wreg = wreg; id_mdu = mdu;
  endtask

  task automatic check_all(input string tag);
    int wn;
    for (int k = 0; k < NI; k++) begin
      wn = m_wn(k);
      chk($sformatf("%s u%0d fwda", tag, k), 32'(fwda[k]), 32'(m_fwd(k, id_use_rs, int'(id_rs))));
      chk($sformatf("%s u%0d fwdb", tag, k), 32'(fwdb[k]), 32'(m_fwd(k, id_use_rt, int'(id_rt))));
      chk($sformatf("%s u%0d nostall", tag, k), 32'(nostall[k]), 32'(m_nostall(k)));
      chk($sformatf("%s u%0d issue", tag, k), 32'(issue[k]), 32'(id_valid && m_nostall(k)));
      chk($sformatf("%s u%0d busy", tag, k), 32'(mdu_busy[k]), 32'(m_busy(k)));
      chk($sformatf("%s u%0d wb", tag, k), 32'(mdu_wb[k]), 32'(wn != 0));
      chk($sformatf("%s u%0d wn", tag, k), 32'(mdu_wn[k]), 32'(wn));
    end
  endtask

  // ---------------- directed table (empty scoreboard) ----------------
  typedef struct {
    int v, rs, urs, rt, urt, ern, ew, em, mrn, mw, mm;
    int fa, fb, ns, ns2;   // u0 fwda/fwdb/nostall, u2 nostall
  } vec_t;

  vec_t tbl [13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    reset   = 1'b1;
    idle();

    //           v rs u rt u ern ew em mrn mw mm  fa fb ns ns2
    tbl[0]  = '{1, 8,1, 0,0, 8, 1, 1, 0, 0, 0,  0, 0, 0, 0};
    tbl[1]  = '{1, 8,1, 0,0, 0, 0, 0, 8, 1, 1,  3, 0, 1, 0};
    tbl[2]  = '{1, 0,0, 5,1, 5, 1, 0, 5, 1, 0,  0, 1, 1, 0};
    tbl[3]  = '{1, 0,0, 0,1, 5, 1, 0, 5, 1, 0,  0, 0, 1, 1};
    tbl[4]  = '{1, 4,1, 0,0, 0, 0, 0, 4, 1, 0,  2, 0, 1, 0};
    tbl[5]  = '{1, 4,0, 0,0, 4, 1, 1, 0, 0, 0,  0, 0, 1, 1};
    tbl[6]  = '{1, 6,1, 6,1, 6, 1, 0, 0, 0, 0,  1, 1, 1, 0};
    tbl[7]  = '{1, 0,1, 0,0, 0, 1, 1, 0, 0, 0,  0, 0, 1, 1};
    tbl[8]  = '{1, 3,1, 0,0, 3, 0, 1, 0, 0, 0,  0, 0, 1, 1};
    tbl[9]  = '{1, 0,0, 7,1, 7, 1, 1, 0, 0, 0,  0, 0, 0, 0};
    tbl[10] = '{0, 8,1, 0,0, 8, 1, 1, 0, 0, 0,  0, 0, 1, 1};
    tbl[11] = '{1, 3,1, 0,0, 3, 1, 0, 0, 0, 0,  1, 0, 1, 0};
    tbl[12] = '{1, 2,1, 2,1, 2, 1, 0, 2, 1, 1,  1, 1, 1, 0};

    do_reset();
    chk("reset busy", 32'(mdu_busy[0]), 0);
    chk("reset wb", 32'(mdu_wb[0]), 0);
    chk("reset wn", 32'(mdu_wn[0]), 0);

    for (int i = 0; i < 13; i++) begin
      idle();
      id_valid = tbl[i].v[0];
      id_rs = AW'(tbl[i].rs); id_use_rs = tbl[i].urs[0];
      id_rt = AW'(tbl[i].rt); id_use_rt = tbl[i].urt[0];
      ern = AW'(tbl[i].ern); ewreg = tbl[i].ew[0]; em2reg = tbl[i].em[0];
      mrn = AW'(tbl[i].mrn); mwreg = tbl[i].mw[0]; mm2reg = tbl[i].mm[0];
      #1;
      chk($sformatf("tbl%0d fwda", i), 32'(fwda[0]), 32'(tbl[i].fa));
      chk($sformatf("tbl%0d fwdb", i), 32'(fwdb[0]), 32'(tbl[i].fb));
      chk($sformatf("tbl%0d nostall", i), 32'(nostall[0]), 32'(tbl[i].ns));
      chk($sformatf("tbl%0d issue", i), 32'(issue[0]), 32'(tbl[i].v & tbl[i].ns));
      chk($sformatf("tbl%0d nofwd nostall", i), 32'(nostall[2]), 32'(tbl[i].ns2));
      chk($sformatf("tbl%0d nofwd fwd", i), 32'({fwda[2], fwdb[2]}), 0);
      tick();
    end

    // ---- MDU rd=9 at cycle 0, dependant add rs=9 from cycle 1 ----
    do_reset();
    present(0, 0, 9, 0, 1);
    #1;
    chk("raw mdu issue c0", 32'(issue[0]), 1);
    tick();
    present(9, 1, 10, 1, 0);
    found = -1;
    for (int c = 1; c <= 12; c++) begin
      if (c == 1) chk("raw busy c1", 32'(mdu_busy[0]), 1);
      if (c == 4) begin
        chk("raw wb c4", 32'(mdu_wb[0]), 1);
        chk("raw wn c4", 32'(mdu_wn[0]), 9);
      end
      if (issue[0] === 1'b1) begin
        found = c;
        break;
      end
      tick();
    end
    chk("raw dependant issue cycle", 32'(found), 5);
    tick();

    // ---- WAW: add rd=9 while an MDU op to 9 is pending ----
    do_reset();
    present(0, 0, 9, 0, 1);
    tick();
    present(0, 0, 9, 1, 0);
    found = -1;
    for (int c = 1; c <= 12; c++) begin
      if (issue[0] === 1'b1) begin
        found = c;
        break;
      end
      tick();
    end
    chk("waw issue cycle", 32'(found), 5);
    tick();

    // ---- structural: back-to-back MDU ops ----
    do_reset();
    present(0, 0, 9, 0, 1);
    tick();
    present(0, 0, 10, 0, 1);
    #1;
    chk("struct pipelined issue c1", 32'(issue[1]), 1);
    found = -1;
    for (int c = 1; c <= 12; c++) begin
      if (issue[0] === 1'b1) begin
        found = c;
        break;
      end
      tick();
    end
    chk("struct serial issue cycle", 32'(found), 5);
    tick();

    // ---- reset discards an in-flight op ----
    do_reset();
    present(0, 0, 7, 0, 1);
    tick();
    idle();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    present(7, 1, 8, 1, 0);
    #1;
    chk("rst consumer nostall", 32'(nostall[0]), 1);
    chk("rst consumer issue", 32'(issue[0]), 1);
    chk("rst busy", 32'(mdu_busy[0]), 0);
    for (int c = 3; c <= 8; c++) begin
      chk($sformatf("rst no wb c%0d", c), 32'(mdu_wb[0]), 0);
      tick();
      idle();
      #1;
    end

    // ---- randomized against the model ----
    do_reset();
    for (int n = 0; n < 800; n++) begin
      reset     = ($urandom_range(0, 79) == 0);
      id_valid  = ($urandom_range(0, 3) != 0);
      id_rs     = AW'($urandom_range(0, 7));
      id_rt     = AW'($urandom_range(0, 7));
      id_rd     = AW'($urandom_range(0, 7));
      id_use_rs = $urandom_range(0, 1) == 1;
      id_use_rt = $urandom_range(0, 1) == 1;
      id_mdu    = ($urandom_range(0, 3) == 0);
      id_wreg   = !id_mdu && ($urandom_range(0, 1) == 1);
      ern       = AW'($urandom_range(0, 7));
      mrn       = AW'($urandom_range(0, 7));
      ewreg     = $urandom_range(0, 1) == 1;
      em2reg    = ($urandom_range(0, 2) == 0);
      mwreg     = $urandom_range(0, 1) == 1;
      mm2reg    = ($urandom_range(0, 2) == 0);
      #1;
      check_all("rnd");
      tick();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
